// File: rtl/computation_gate_issue.sv
// Operand-issue / result-capture stage for a single gate-function unit, one operation in flight.
// Optional WAIT watchdog enabled by defining GATE_ISSUE_TIMEOUT_EN.
module computation_gate_issue #(
    parameter int unsigned F_NBITS  = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_BITS = 16,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [F_NBITS-1:0]  op_in0,
    input  logic [F_NBITS-1:0]  op_in1,
    input  logic                op_sel,
    output logic                gate_en,
    output logic                gate_mux_sel,
    output logic [F_NBITS-1:0]  gate_in0,
    output logic [F_NBITS-1:0]  gate_in1,
    input  logic                gate_ready_pulse,
    input  logic [F_NBITS-1:0]  gate_out,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [F_NBITS-1:0]  res_data,
    output logic                busy,
    output logic [CNT_BITS-1:0] done_count,
    output logic                timeout_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 2 * F_NBITS + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e               state_q, state_d;
    logic [EW-1:0]        mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic                 op_ready_q, op_ready_d;
    logic                 sel_q, sel_d;
    logic [F_NBITS-1:0]   in0_q, in0_d, in1_q, in1_d;
    logic                 res_valid_q, res_valid_d;
    logic [F_NBITS-1:0]   res_data_q, res_data_d;
    logic [CNT_BITS-1:0]  done_q, done_d;
    logic [EW-1:0]        head;
    logic                 push, pop, slot_free, res_hs, capture, tmo_hit;

    assign head      = mem_q[rd_ptr_q];
    assign push      = op_valid && op_ready_q;
    assign slot_free = !res_valid_q || res_ready;
    assign pop       = (state_q == StIdle) && (cnt_q != '0) && slot_free;
    assign res_hs    = res_valid_q && res_ready;
    assign capture   = (state_q == StWait) && gate_ready_pulse;

`ifdef GATE_ISSUE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_err_q, tmo_err_d;

    // Pulse arriving in the final cycle wins over the watchdog.
    assign tmo_hit = (state_q == StWait) && !gate_ready_pulse && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        tmo_d     = '0;
        tmo_err_d = tmo_err_q || tmo_hit;
        if ((state_q == StWait) && !gate_ready_pulse && !tmo_hit) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + (AW + 1)'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - (AW + 1)'(1);
        end
        // Registered full flag: stays low for the pop cycle, reasserts the cycle after.
        op_ready_d = (cnt_d != (AW + 1)'(DEPTH));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pop) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (gate_ready_pulse || tmo_hit) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sel_d       = sel_q;
        in0_d       = in0_q;
        in1_d       = in1_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        done_d      = done_q;
        if (pop) begin
            {sel_d, in0_d, in1_d} = head;
        end
        if (res_hs) begin
            res_valid_d = 1'b0;
            done_d      = done_q + CNT_BITS'(1);
        end
        if (capture) begin
            res_valid_d = 1'b1;
            res_data_d  = gate_out;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {op_sel, op_in0, op_in1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            op_ready_q  <= 1'b1;
            sel_q       <= 1'b0;
            in0_q       <= '0;
            in1_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            op_ready_q  <= op_ready_d;
            sel_q       <= sel_d;
            in0_q       <= in0_d;
            in1_q       <= in1_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            done_q      <= done_d;
        end
    end

    assign op_ready     = op_ready_q;
    assign gate_en      = (state_q == StIssue);
    assign gate_mux_sel = sel_q;
    assign gate_in0     = in0_q;
    assign gate_in1     = in1_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign done_count   = done_q;
    assign busy         = (cnt_q != '0) || (state_q != StIdle) || res_valid_q;

endmodule

// File: tb/tb_computation_gate_issue.sv
// Directed bench for computation_gate_issue with a behavioural add/mux gate unit.
// Timeout checks run only when GATE_ISSUE_TIMEOUT_EN is defined.
module tb_computation_gate_issue;

    localparam int unsigned FW = 8;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [FW-1:0] op_in0 = '0;
    logic [FW-1:0] op_in1 = '0;
    logic          op_sel = 1'b0;
    logic          gate_en;
    logic          gate_mux_sel;
    logic [FW-1:0] gate_in0, gate_in1;
    logic          gate_ready_pulse;
    logic [FW-1:0] gate_out;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [FW-1:0] res_data;
    logic          busy;
    logic [CW-1:0] done_count;
    logic          timeout_err;

    int n_asrt = 0;
    int n_fail = 0;

    // Gate unit model: add when sel=0, mux picks in1 when sel=1; latency g_lat cycles.
    logic          g_pulse = 1'b0;
    logic [FW-1:0] g_out = '0;
    logic [FW-1:0] g_res = '0;
    int            g_left = 0;
    int            g_lat = 1;
    logic          g_mute = 1'b0;
    logic          man_pulse = 1'b0;
    logic [FW-1:0] man_out = '0;
    int            en_cnt = 0;

    assign gate_ready_pulse = g_pulse | man_pulse;
    assign gate_out         = man_pulse ? man_out : g_out;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        logic [FW-1:0] v;
        v = gate_mux_sel ? gate_in1 : FW'(gate_in0 + gate_in1);
        g_pulse <= 1'b0;
        if (gate_en) en_cnt <= en_cnt + 1;
        if (g_left != 0) begin
            g_left <= g_left - 1;
            if (g_left == 1) begin
                g_pulse <= 1'b1;
                g_out   <= g_res;
            end
        end
        if (gate_en && !g_mute) begin
            g_res <= v;
            if (g_lat == 1) begin
                g_pulse <= 1'b1;
                g_out   <= v;
            end else begin
                g_left <= g_lat - 1;
            end
        end
    end

    computation_gate_issue #(
        .F_NBITS (FW),
        .DEPTH   (4),
        .CNT_BITS(CW),
        .TIMEOUT (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .op_in0          (op_in0),
        .op_in1          (op_in1),
        .op_sel          (op_sel),
        .gate_en         (gate_en),
        .gate_mux_sel    (gate_mux_sel),
        .gate_in0        (gate_in0),
        .gate_in1        (gate_in1),
        .gate_ready_pulse(gate_ready_pulse),
        .gate_out        (gate_out),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .busy            (busy),
        .done_count      (done_count),
        .timeout_err     (timeout_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_op_ready"}, op_ready, 1);
        check({tag, "_gate_en"}, gate_en, 0);
        check({tag, "_mux_sel"}, gate_mux_sel, 0);
        check({tag, "_gate_in0"}, gate_in0, 0);
        check({tag, "_gate_in1"}, gate_in1, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done_count"}, done_count, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        int en0;
        int k;
        logic push_now;

        // Reset state
        step();
        step();
        check_reset_values("rst");
        rst = 1'b0;
        step();

        // Single add op, L=1
        res_ready = 1'b1;
        op_valid = 1'b1; op_sel = 1'b0; op_in0 = 8'd5; op_in1 = 8'd7;
        check("t1_op_ready", op_ready, 1);
        step();                                   // t+1
        op_valid = 1'b0;
        check("t1_no_early_en", gate_en, 0);
        check("t1_busy", busy, 1);
        step();                                   // t+2
        check("t1_gate_en", gate_en, 1);
        check("t1_gate_in0", gate_in0, 5);
        check("t1_gate_in1", gate_in1, 7);
        check("t1_mux_sel", gate_mux_sel, 0);
        step();                                   // t+3
        check("t1_no_early_res", res_valid, 0);
        step();                                   // t+4
        check("t1_res_valid", res_valid, 1);
        check("t1_res_data", res_data, 12);
        step();
        check("t1_res_drained", res_valid, 0);
        check("t1_done_count", done_count, 1);
        check("t1_idle_busy", busy, 0);

        // Mux op with L=3, select held through WAIT
        g_lat = 3;
        op_valid = 1'b1; op_sel = 1'b1; op_in0 = 8'd3; op_in1 = 8'd9;
        step();
        op_valid = 1'b0; op_sel = 1'b0;
        step();                                   // ISSUE
        check("mux_gate_en", gate_en, 1);
        check("mux_sel_issue", gate_mux_sel, 1);
        check("mux_in0", gate_in0, 3);
        check("mux_in1", gate_in1, 9);
        step();
        check("mux_sel_wait1", gate_mux_sel, 1);
        step();
        check("mux_sel_wait2", gate_mux_sel, 1);
        check("mux_no_res", res_valid, 0);
        step();                                   // pulse cycle
        check("mux_sel_pulse", gate_mux_sel, 1);
        check("mux_in1_pulse", gate_in1, 9);
        step();
        check("mux_res_valid", res_valid, 1);
        check("mux_res_data", res_data, 9);
        step();
        check("mux_done_count", done_count, 2);
        g_lat = 1;

        // FIFO fill with stalled downstream
        res_ready = 1'b0;
        en0 = en_cnt;
        for (int i = 0; i < 6; i++) begin
            op_valid = 1'b1; op_in0 = FW'(i + 1); op_in1 = 8'd16;
            if (i < 5) begin
                check("fill_op_ready", op_ready, 1);
                step();
            end else begin
                check("full_op_ready", op_ready, 0);
            end
        end
        step(); step(); step();
        check("full_op_ready_hold", op_ready, 0);
        check("single_issue", en_cnt - en0, 1);
        check("fill_res_valid", res_valid, 1);
        check("fill_res_first", res_data, 17);
        res_ready = 1'b1;
        step();
        check("no_bubble_issue", gate_en, 1);
        check("op_ready_reassert", op_ready, 1);
        check("no_bubble_res_clear", res_valid, 0);
        k = 1;
        for (int cyc = 0; cyc < 100 && k < 6; cyc++) begin
            if (res_valid) begin
                check("fifo_order", res_data, k + 17);
                k++;
            end
            push_now = op_valid && op_ready;
            step();
            if (push_now) op_valid = 1'b0;
        end
        check("drain_count", k, 6);
        check("drain_done_count", done_count, 8);
        check("drain_busy", busy, 0);

        // Reset two cycles after gate_en, with a second op queued
        g_mute = 1'b1;
        op_valid = 1'b1; op_in0 = 8'd2; op_in1 = 8'd2;
        step();
        op_in0 = 8'd3; op_in1 = 8'd3;
        step();                                   // ISSUE
        op_valid = 1'b0;
        check("rw_gate_en", gate_en, 1);
        step();
        step();
        rst = 1'b1;
        #1;
        check_reset_values("midwait");
        en0 = en_cnt;
        step();
        rst = 1'b0;
        step();
        man_pulse = 1'b1; man_out = 8'h55;
        step();
        man_pulse = 1'b0;
        step();
        step();
        check("late_pulse_res_valid", res_valid, 0);
        check("late_pulse_res_data", res_data, 0);
        check("late_pulse_done", done_count, 0);
        check("rst_fifo_empty_busy", busy, 0);
        check("rst_no_issue", en_cnt - en0, 0);

`ifdef GATE_ISSUE_TIMEOUT_EN
        // Watchdog drops a silent op, next op issues normally
        op_valid = 1'b1; op_in0 = 8'd1; op_in1 = 8'd1;
        step();                                   // t+1
        op_in0 = 8'd4; op_in1 = 8'd5;
        step();                                   // t+2 ISSUE
        op_valid = 1'b0;
        check("to_gate_en", gate_en, 1);
        repeat (8) step();                        // t+10
        check("to_not_yet", timeout_err, 0);
        step();                                   // t+11
        check("to_err_set", timeout_err, 1);
        check("to_no_result", res_valid, 0);
        g_mute = 1'b0;
        step();                                   // t+12
        check("to_next_issue", gate_en, 1);
        check("to_next_in0", gate_in0, 4);
        step();
        step();
        check("to_next_res", res_data, 9);
        check("to_next_valid", res_valid, 1);
        step();
        check("to_done_count", done_count, 1);
        check("to_err_sticky", timeout_err, 1);
`else
        // Without the watchdog WAIT persists
        op_valid = 1'b1; op_in0 = 8'd1; op_in1 = 8'd1;
        step();
        op_valid = 1'b0;
        repeat (25) step();
        check("nto_err_zero", timeout_err, 0);
        check("nto_still_busy", busy, 1);
        check("nto_no_result", res_valid, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        g_mute = 1'b0;
        step();
        check("nto_rst_busy", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
